ppu_oam_scanner: RTL and testbench

Parametrised OAM scan engine for the PPU's mode-2 (OAM search) phase. On a start pulse it walks all OAM entries through a single byte-read port with 1-cycle latency. It selects up to MAX_SPRITES sprites whose vertical span covers the current scanline, supporting both 8x8 and 8x16 sprites. The selected Y/X/tile/attribute bytes are buffered for the draw-phase sprite fetcher to read by index.

---
 rtl/ppu_oam_scanner.sv | 185 ++++++++++++++++++
 tb/tb_ppu_oam_scanner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_oam_scanner.sv
// OAM search engine: walks every OAM entry through a 1-cycle-latency byte port
// and buffers up to MAX_SPRITES entries whose vertical span covers the latched scanline.
module ppu_oam_scanner #(
    parameter int          NUM_ENTRIES = 40,
    parameter int          MAX_SPRITES = 10,
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    parameter int          IW          = $clog2(MAX_SPRITES),
    parameter int          CW          = $clog2(MAX_SPRITES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    ly,
    input  logic          tall,
    output logic          oam_rd,
    output logic [15:0]   oam_addr,
    input  logic [7:0]    oam_data,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sp_count,
    output logic          sp_overflow,
    input  logic [IW-1:0] q_idx,
    output logic [7:0]    q_y,
    output logic [7:0]    q_x,
    output logic [7:0]    q_tile,
    output logic [7:0]    q_attr
);
    localparam int EW = $clog2(NUM_ENTRIES);

    typedef enum logic [2:0] {IDLE, Y_REQ, Y_CHK, X_CAP, T_CAP, A_CAP, FIN} state_t;

    state_t        state;
    logic [EW-1:0] idx;
    logic [7:0]    ly_l;
    logic          tall_l;
    logic [15:0]   addr_hold;
    logic [7:0]    buf_y    [MAX_SPRITES];
    logic [7:0]    buf_x    [MAX_SPRITES];
    logic [7:0]    buf_tile [MAX_SPRITES];
    logic [7:0]    buf_attr [MAX_SPRITES];

    logic          last;
    logic          full;
    logic          match;
    logic [8:0]    line9;
    logic [8:0]    y9;
    logic [8:0]    h9;
    logic [15:0]   entry_base;
    logic [15:0]   next_base;
    logic [IW-1:0] wr_idx;
    logic          rd_hit;

    always_comb begin
        last       = (idx == EW'(NUM_ENTRIES - 1));
        full       = (sp_count == CW'(MAX_SPRITES));
        // 9-bit compare so Y near 255 plus height cannot wrap into a false match
        line9      = {1'b0, ly_l} + 9'd16;
        y9         = {1'b0, oam_data};
        h9         = tall_l ? 9'd16 : 9'd8;
        match      = (line9 >= y9) && (line9 < y9 + h9);
        entry_base = OAM_BASE + 16'({idx, 2'b00});
        next_base  = entry_base + 16'd4;
        wr_idx     = sp_count[IW-1:0];
    end

    // Address is data dependent in Y_CHK, so the read port is decoded combinationally.
    always_comb begin
        oam_rd   = 1'b0;
        oam_addr = addr_hold;
        case (state)
            Y_REQ: begin
                oam_rd   = 1'b1;
                oam_addr = entry_base;
            end
            Y_CHK: begin
                if (match && !full) begin
                    oam_rd   = 1'b1;
                    oam_addr = entry_base + 16'd1;
                end else if (!last) begin
                    oam_rd   = 1'b1;
                    oam_addr = next_base;
                end
            end
            X_CAP: begin
                oam_rd   = 1'b1;
                oam_addr = entry_base + 16'd2;
            end
            T_CAP: begin
                oam_rd   = 1'b1;
                oam_addr = entry_base + 16'd3;
            end
            A_CAP: begin
                if (!last) begin
                    oam_rd   = 1'b1;
                    oam_addr = next_base;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            ly_l        <= '0;
            tall_l      <= 1'b0;
            sp_count    <= '0;
            sp_overflow <= 1'b0;
            addr_hold   <= OAM_BASE;
            for (int k = 0; k < MAX_SPRITES; k++) begin
                buf_y[k]    <= '0;
                buf_x[k]    <= '0;
                buf_tile[k] <= '0;
                buf_attr[k] <= '0;
            end
        end else begin
            addr_hold <= oam_addr;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ly_l        <= ly;
                        tall_l      <= tall;
                        sp_count    <= '0;
                        sp_overflow <= 1'b0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= Y_REQ;
                    end
                end
                Y_REQ: state <= Y_CHK;
                Y_CHK: begin
                    if (match && !full) begin
                        buf_y[wr_idx] <= oam_data;
                        state         <= X_CAP;
                    end else begin
                        if (match) sp_overflow <= 1'b1;
                        if (!last) begin
                            idx <= idx + EW'(1);
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                X_CAP: begin
                    buf_x[wr_idx] <= oam_data;
                    state         <= T_CAP;
                end
                T_CAP: begin
                    buf_tile[wr_idx] <= tall_l ? (oam_data & 8'hFE) : oam_data;
                    state            <= A_CAP;
                end
                A_CAP: begin
                    buf_attr[wr_idx] <= oam_data;
                    sp_count         <= sp_count + CW'(1);
                    if (!last) begin
                        idx   <= idx + EW'(1);
                        state <= Y_CHK;
                    end else begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stale entries from earlier lines stay in the buffer but are masked by sp_count.
    always_comb begin
        rd_hit = (CW'(q_idx) < sp_count);
        q_y    = rd_hit ? buf_y[q_idx]    : 8'h00;
        q_x    = rd_hit ? buf_x[q_idx]    : 8'h00;
        q_tile = rd_hit ? buf_tile[q_idx] : 8'h00;
        q_attr = rd_hit ? buf_attr[q_idx] : 8'h00;
    end
endmodule

// File: tb/tb_ppu_oam_scanner.sv
// Bench for ppu_oam_scanner: OAM byte memory with 1-cycle read latency and a
// reference model that derives the selected sprites and address trace from OAM contents.
module tb_ppu_oam_scanner;
    localparam int          NE   = 40;
    localparam int          MS   = 10;
    localparam logic [15:0] BASE = 16'hFE00;

    logic        clk, rst, start, tall, oam_rd, busy, done, sp_overflow;
    logic [7:0]  ly, oam_data, q_y, q_x, q_tile, q_attr;
    logic [15:0] oam_addr;
    logic [3:0]  sp_count, q_idx;

    logic [7:0]  oam_mem [NE*4];
    logic [7:0]  exp_y[$], exp_x[$], exp_t[$], exp_a[$];
    logic [15:0] exp_addr[$], got_addr[$];
    logic        exp_ovf;
    int          vectors, miscompares, lat;

    ppu_oam_scanner dut (
        .clk(clk), .rst(rst), .start(start), .ly(ly), .tall(tall),
        .oam_rd(oam_rd), .oam_addr(oam_addr), .oam_data(oam_data),
        .busy(busy), .done(done), .sp_count(sp_count), .sp_overflow(sp_overflow),
        .q_idx(q_idx), .q_y(q_y), .q_x(q_x), .q_tile(q_tile), .q_attr(q_attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        oam_data <= oam_rd ? oam_mem[int'(oam_addr - BASE)] : 8'h00;

    // Reference: a sprite is on the line when Y-16 <= ly < Y-16+h; first MS in OAM order kept.
    function automatic void build_model(input logic [7:0] l, input logic t);
        int h, y, line;
        exp_y.delete(); exp_x.delete(); exp_t.delete(); exp_a.delete(); exp_addr.delete();
        exp_ovf = 1'b0;
        h = t ? 16 : 8;
        line = int'(l);
        for (int e = 0; e < NE; e++) begin
            y = int'(oam_mem[4*e]);
            exp_addr.push_back(BASE + 16'(4*e));
            if (line >= y - 16 && line < y - 16 + h) begin
                if (exp_y.size() < MS) begin
                    exp_y.push_back(oam_mem[4*e]);
                    exp_x.push_back(oam_mem[4*e+1]);
                    exp_t.push_back(t ? (oam_mem[4*e+2] & 8'hFE) : oam_mem[4*e+2]);
                    exp_a.push_back(oam_mem[4*e+3]);
                    for (int b = 1; b < 4; b++) exp_addr.push_back(BASE + 16'(4*e + b));
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endfunction

    task automatic clear_oam();
        for (int k = 0; k < NE*4; k++) oam_mem[k] = 8'($urandom_range(0, 255));
        for (int e = 0; e < NE; e++) oam_mem[4*e] = 8'h00;
    endtask

    // Drive one start pulse, record the read trace, wait (bounded) for done.
    task automatic run_scan(input logic [7:0] l, input logic t);
        @(negedge clk); ly = l; tall = t; start = 1'b1;
        @(negedge clk); start = 1'b0; ly = ~l; tall = ~t;
        got_addr.delete(); lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            if (oam_rd === 1'b1) got_addr.push_back(oam_addr);
            @(negedge clk); lat++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL scan_done: done=%b after %0d cycles, want 1", done, lat);
        end else if (oam_rd !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL done_cycle: oam_rd=%b busy=%b, want 0 1", oam_rd, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ly = 8'd0; tall = 1'b0; q_idx = 4'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({oam_rd, busy, done, sp_overflow} !== 4'b0000 || sp_count !== 4'd0 ||
            oam_addr !== BASE || {q_y, q_x, q_tile, q_attr} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: rd=%b busy=%b done=%b ovf=%b cnt=%0d addr=%h q=%h, want zeros addr=fe00",
                     oam_rd, busy, done, sp_overflow, sp_count, oam_addr, {q_y, q_x, q_tile, q_attr});
        end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        int bad;
        clear_oam();
        build_model(8'd50, 1'b0);
        run_scan(8'd50, 1'b0);
        vectors++;
        if (lat !== 42 || sp_count !== 4'd0 || sp_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL empty: lat=%0d cnt=%0d ovf=%b, want 42 0 0", lat, sp_count, sp_overflow);
        end
        bad = (got_addr.size() != 40) ? 1 : 0;
        foreach (got_addr[k]) if (got_addr[k] !== BASE + 16'(4*k)) bad = 1;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL empty_addr: %0d reads last=%h, want 40 reads fe00..fe9c", got_addr.size(),
                     got_addr.size() > 0 ? got_addr[got_addr.size()-1] : 16'h0);
        end
    endtask

    task automatic test_single_hit();
        logic [7:0] lines [4] = '{8'd50, 8'd51, 8'd52, 8'd44};
        logic [3:0] want  [4] = '{4'd1, 4'd1, 4'd0, 4'd1};
        clear_oam();
        oam_mem[20] = 8'd60; oam_mem[21] = 8'd20; oam_mem[22] = 8'h13; oam_mem[23] = 8'h80;
        run_scan(8'd50, 1'b0);
        q_idx = 4'd0; #1;
        vectors++;
        if (lat !== 45 || sp_count !== 4'd1 || {q_y, q_x, q_tile, q_attr} !== {8'd60, 8'd20, 8'h13, 8'h80}) begin
            miscompares++;
            $display("FAIL single_hit: lat=%0d cnt=%0d q=%h, want 45 1 3c141380",
                     lat, sp_count, {q_y, q_x, q_tile, q_attr});
        end
        q_idx = 4'd1; #1;
        vectors++;
        if ({q_y, q_x, q_tile, q_attr} !== 32'h0) begin
            miscompares++;
            $display("FAIL single_mask: q[1]=%h, want 0", {q_y, q_x, q_tile, q_attr});
        end
        for (int k = 1; k < 4; k++) begin
            run_scan(lines[k], 1'b0);
            vectors++;
            if (sp_count !== want[k] || lat !== 42 + 3*int'(want[k])) begin
                miscompares++;
                $display("FAIL boundary ly=%0d: cnt=%0d lat=%0d, want %0d %0d",
                         lines[k], sp_count, lat, want[k], 42 + 3*int'(want[k]));
            end
        end
    endtask

    task automatic test_tall();
        clear_oam();
        oam_mem[0] = 8'd60; oam_mem[1] = 8'd33; oam_mem[2] = 8'h27; oam_mem[3] = 8'h10;
        run_scan(8'd55, 1'b0);
        vectors++;
        if (sp_count !== 4'd0) begin
            miscompares++;
            $display("FAIL tall_off: cnt=%0d, want 0", sp_count);
        end
        run_scan(8'd55, 1'b1);
        q_idx = 4'd0; #1;
        vectors++;
        if (sp_count !== 4'd1 || q_tile !== 8'h26 || q_y !== 8'd60) begin
            miscompares++;
            $display("FAIL tall_on: cnt=%0d tile=%h y=%0d, want 1 26 60", sp_count, q_tile, q_y);
        end
    endtask

    task automatic test_overflow();
        clear_oam();
        for (int e = 0; e < 12; e++) begin
            oam_mem[4*e] = 8'd70; oam_mem[4*e+1] = 8'(e); oam_mem[4*e+2] = 8'(8'h40 + e);
        end
        build_model(8'd60, 1'b0);
        run_scan(8'd60, 1'b0);
        vectors++;
        if (lat !== 72 || sp_count !== 4'd10 || sp_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: lat=%0d cnt=%0d ovf=%b, want 72 10 1", lat, sp_count, sp_overflow);
        end
        for (int k = 0; k < MS + 2; k++) begin
            q_idx = 4'(k); #1;
            vectors++;
            if ({q_y, q_x, q_tile, q_attr} !== (k < exp_y.size() ? {exp_y[k], exp_x[k], exp_t[k], exp_a[k]} : 32'h0)) begin
                miscompares++;
                $display("FAIL overflow_entry[%0d]: got %h, want %h", k, {q_y, q_x, q_tile, q_attr},
                         k < exp_y.size() ? {exp_y[k], exp_x[k], exp_t[k], exp_a[k]} : 32'h0);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] l;
        logic       t;
        int         bad;
        for (int it = 0; it < 8; it++) begin
            l = 8'($urandom_range(0, 143));
            t = 1'($urandom_range(0, 1));
            for (int k = 0; k < NE*4; k++) oam_mem[k] = 8'($urandom_range(0, 255));
            for (int e = 0; e < NE; e++)
                if ($urandom_range(0, 3) != 0) oam_mem[4*e] = 8'(int'(l) + 16 - $urandom_range(0, 17));
            build_model(l, t);
            run_scan(l, t);
            vectors++;
            if (lat !== 42 + 3*exp_y.size() || sp_count !== 4'(exp_y.size()) || sp_overflow !== exp_ovf) begin
                miscompares++;
                $display("FAIL random%0d: lat=%0d cnt=%0d ovf=%b, want %0d %0d %b", it, lat, sp_count,
                         sp_overflow, 42 + 3*exp_y.size(), exp_y.size(), exp_ovf);
            end
            bad = (got_addr.size() != exp_addr.size()) ? 1 : 0;
            if (bad == 0) foreach (got_addr[k]) if (got_addr[k] !== exp_addr[k]) bad = 1;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL random%0d_addr: %0d reads, want %0d matching model trace",
                         it, got_addr.size(), exp_addr.size());
            end
            for (int k = 0; k < MS + 2; k++) begin
                q_idx = 4'(k); #1;
                vectors++;
                if ({q_y, q_x, q_tile, q_attr} !== (k < exp_y.size() ? {exp_y[k], exp_x[k], exp_t[k], exp_a[k]} : 32'h0)) begin
                    miscompares++;
                    $display("FAIL random%0d_entry[%0d]: got %h, want %h", it, k, {q_y, q_x, q_tile, q_attr},
                             k < exp_y.size() ? {exp_y[k], exp_x[k], exp_t[k], exp_a[k]} : 32'h0);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        clear_oam();
        for (int e = 0; e < 6; e++) oam_mem[8*e] = 8'd90;
        @(negedge clk); ly = 8'd80; tall = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || sp_count !== 4'd0 || oam_rd !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b cnt=%0d rd=%b done=%b, want 0 0 0 0", busy, sp_count, oam_rd, done);
        end
        rst = 1'b0;
        dones = 0;
        repeat (60) begin @(negedge clk); if (done === 1'b1) dones++; end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL mid_reset_done: %0d done pulses, want 0", dones);
        end
        build_model(8'd80, 1'b0);
        run_scan(8'd80, 1'b0);
        vectors++;
        if (sp_count !== 4'(exp_y.size()) || lat !== 42 + 3*exp_y.size()) begin
            miscompares++;
            $display("FAIL rescan: cnt=%0d lat=%0d, want %0d %0d", sp_count, lat, exp_y.size(), 42 + 3*exp_y.size());
        end
    endtask

    task automatic test_back_to_back();
        int dones, lat2;
        clear_oam();
        for (int e = 0; e < 3; e++) oam_mem[12*e] = 8'd40;
        build_model(8'd30, 1'b0);
        @(negedge clk); ly = 8'd30; tall = 1'b0; start = 1'b1;
        @(negedge clk);
        lat = 1; dones = 0;
        while (done !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        if (done === 1'b1) dones++;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || dones != 1 || lat != 42 + 3*exp_y.size()) begin
            miscompares++;
            $display("FAIL b2b_gap: busy=%b done=%b dones=%0d lat=%0d, want 0 0 1 %0d",
                     busy, done, dones, lat, 42 + 3*exp_y.size());
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_restart: busy=%b, want 1", busy);
        end
        lat2 = 1;
        while (done !== 1'b1 && lat2 < 200) begin @(negedge clk); lat2++; end
        vectors++;
        if (lat2 != 42 + 3*exp_y.size() || sp_count !== 4'(exp_y.size())) begin
            miscompares++;
            $display("FAIL b2b_second: lat=%0d cnt=%0d, want %0d %0d", lat2, sp_count,
                     42 + 3*exp_y.size(), exp_y.size());
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        for (int k = 0; k < NE*4; k++) oam_mem[k] = 8'h00;
        test_reset();
        test_empty();
        test_single_hit();
        test_tall();
        test_overflow();
        test_random();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
